// File: rtl/fetch_seq_pkg.sv
// ---------------------------------------------------------------------------
// fetch_seq_pkg
//
// Shared definitions for the fetch/execute sequencer:
//   - fetch_state_e : sequencer FSM states
//   - npc_sel_e     : which source the next program counter is taken from
//   - DEFAULT_RESET_PC : program counter value loaded while reset is held
// ---------------------------------------------------------------------------
package fetch_seq_pkg;

    // PC value loaded on reset unless the top is parameterised otherwise
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

    // Sequencer states. IDLE is only ever entered through reset.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        EXEC = 3'd3,
        HALT = 3'd4
    } fetch_state_e;

    // Next-PC source, resolved by priority JUMP > BRANCH > SEQ
    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2
    } npc_sel_e;

endpackage : fetch_seq_pkg

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
//
// Purely combinational next program counter. Picks an offset by priority
// (jump, then taken branch, then sequential +1) and adds it to the current
// PC. The PC is word-addressed and all arithmetic wraps modulo 2^32.
//
// Ports:
//   pc             in  32  current program counter
//   jump           in  1   current instruction is a jump
//   jump_addr      in  32  jump offset (added to pc)
//   branch         in  1   current instruction is a branch
//   pc_src         in  1   branch condition is true
//   branch_address in  16  branch offset, zero-extended before the add
//   next_pc        out 32  selected next program counter
// ---------------------------------------------------------------------------
module pc_next_calc
    import fetch_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    input  logic        branch,
    input  logic        pc_src,
    input  logic [15:0] branch_address,
    output logic [31:0] next_pc
);

    npc_sel_e    sel;
    logic [31:0] offset;

    // Priority select: a jump wins even when a taken branch is also flagged
    always_comb begin
        sel = SEQ;
        if (jump) begin
            sel = JUMP;
        end else if (branch && pc_src) begin
            sel = BRANCH;
        end
    end

    // Offset mux followed by a single shared adder; the branch offset is
    // zero-extended, so a branch can only move the PC forward
    always_comb begin
        offset = 32'd1;
        case (sel)
            JUMP:    offset = jump_addr;
            BRANCH:  offset = {16'b0, branch_address};
            SEQ:     offset = 32'd1;
            default: offset = 32'd1;
        endcase
        next_pc = pc + offset;
    end

endmodule : pc_next_calc

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Multi-cycle fetch/execute sequencer owning the core's program counter.
// Issues a fetch over a request/grant/response handshake, captures the
// returned instruction, holds it for the datapath until execution finishes,
// then advances the PC (jump / taken branch / sequential) and counts the
// retired instruction. Supports halting after an instruction retires and
// resuming later.
//
// Ports:
//   clk            in  1       clock, rising edge
//   rst            in  1       asynchronous, active-low reset
//   imem_req       out 1       fetch request (REQ state only)
//   imem_addr      out 32      fetch address, always equal to pc
//   imem_gnt       in  1       memory accepted the request
//   imem_rvalid    in  1       imem_rdata is valid
//   imem_rdata     in  INST_W  returned instruction
//   inst           out INST_W  captured instruction for decode
//   inst_valid     out 1       inst is being executed (EXEC state only)
//   exec_done      in  1       datapath finished; next-PC inputs valid
//   JumpSignal     in  1       current instruction is a jump
//   Jump_addr      in  32      jump offset
//   BranchSignal   in  1       current instruction is a branch
//   PCsrc          in  1       branch condition true
//   branch_address in  16      branch offset, zero-extended
//   halt_req       in  1       halt after the current instruction retires
//   resume         in  1       leave HALT
//   pc             out 32      current program counter
//   halted         out 1       sequencer is in HALT
//   retired        out 32      retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              exec_done,
    input  logic              JumpSignal,
    input  logic [31:0]       Jump_addr,
    input  logic              BranchSignal,
    input  logic              PCsrc,
    input  logic [15:0]       branch_address,
    input  logic              halt_req,
    input  logic              resume,
    output logic [31:0]       pc,
    output logic              halted,
    output logic [31:0]       retired
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  next_pc;

    // Each condition only has meaning in its own state, so any input seen
    // outside that state is simply ignored
    logic capture_inst;
    logic retire_inst;

    assign capture_inst = (state_q == RESP) && imem_rvalid;
    assign retire_inst  = (state_q == EXEC) && exec_done;

    pc_next_calc u_pc_next_calc (
        .pc             (pc),
        .jump           (JumpSignal),
        .jump_addr      (Jump_addr),
        .branch         (BranchSignal),
        .pc_src         (PCsrc),
        .branch_address (branch_address),
        .next_pc        (next_pc)
    );

    // State register; reset aborts any outstanding fetch immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    state_d = halt_req ? HALT : REQ;
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decode the state register only, so no input reaches
    // them combinationally
    always_comb begin
        imem_req   = (state_q == REQ);
        inst_valid = (state_q == EXEC);
        halted     = (state_q == HALT);
        imem_addr  = pc;
    end

    // Instruction capture, PC update and retire counter. The PC and the
    // counter move on the same edge that leaves EXEC, so the new PC is
    // already on imem_addr in the following REQ cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            inst    <= '0;
            retired <= '0;
        end else begin
            if (capture_inst) begin
                inst <= imem_rdata;
            end
            if (retire_inst) begin
                pc      <= next_pc;
                retired <= retired + 32'd1;
            end
        end
    end

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed self-checking bench for fetch_sequencer. Inputs are driven on the
// falling edge and outputs are sampled on the falling edge, half a cycle
// away from the active rising edge. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exec_done;
    logic        JumpSignal;
    logic [31:0] Jump_addr;
    logic        BranchSignal;
    logic        PCsrc;
    logic [15:0] branch_address;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] retired;

    int          checks;
    int          errors;
    logic [31:0] expRetired;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .exec_done      (exec_done),
        .JumpSignal     (JumpSignal),
        .Jump_addr      (Jump_addr),
        .BranchSignal   (BranchSignal),
        .PCsrc          (PCsrc),
        .branch_address (branch_address),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc             (pc),
        .halted         (halted),
        .retired        (retired)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive every DUT input in one go
    task automatic applyStimulus(input logic gnt, input logic rv, input logic [31:0] rd,
                                 input logic done, input logic j, input logic [31:0] ja,
                                 input logic b, input logic ps, input logic [15:0] ba,
                                 input logic hr, input logic res);
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        exec_done      = done;
        JumpSignal     = j;
        Jump_addr      = ja;
        BranchSignal   = b;
        PCsrc          = ps;
        branch_address = ba;
        halt_req       = hr;
        resume         = res;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    // One zero-wait instruction, entered on a falling edge while in REQ and
    // left on the falling edge after EXEC retires it
    task automatic doInstr(input string tag, input logic j, input logic [31:0] ja,
                           input logic b, input logic ps, input logic [15:0] ba,
                           input logic [31:0] rd, input logic hr);
        checkOutput({tag, "_req"}, 32'(imem_req), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, rd, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_inst"}, inst, rd);
        checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, j, ja, b, ps, ba, hr, 1'b0);
        @(negedge clk);
        expRetired = expRetired + 32'd1;
        idleInputs();
        checkOutput({tag, "_retired"}, retired, expRetired);
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        expRetired = 32'd0;
        rst        = 1'b0;
        idleInputs();

        // Reset state
        @(negedge clk);
        checkOutput("rst_req",     32'(imem_req),   32'd0);
        checkOutput("rst_valid",   32'(inst_valid), 32'd0);
        checkOutput("rst_halted",  32'(halted),     32'd0);
        checkOutput("rst_addr",    imem_addr,       32'd0);
        checkOutput("rst_retired", retired,         32'd0);
        checkOutput("rst_inst",    inst,            32'd0);

        // Free-running fetch: every handshake answered immediately
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k % 3 == 1) begin
                checkOutput("seq_req",  32'(imem_req), 32'd1);
                checkOutput("seq_addr", imem_addr,     32'((k - 1) / 3));
            end else if (k % 3 == 0) begin
                checkOutput("seq_valid", 32'(inst_valid), 32'd1);
                checkOutput("seq_inst",  inst,            32'h1234_5678);
            end else begin
                checkOutput("seq_resp_noreq", 32'(imem_req), 32'd0);
            end
        end
        @(negedge clk);
        idleInputs();
        expRetired = 32'd4;
        checkOutput("seq_retired4", retired,   32'd4);
        checkOutput("seq_addr4",    imem_addr, 32'd4);

        // Next-PC selection and wrap-around
        doInstr("jmp6", 1'b1, 32'd6, 1'b0, 1'b0, 16'd0, 32'hA000_0001, 1'b0);
        checkOutput("jmp6_addr", imem_addr, 32'd10);
        doInstr("jmp_wins", 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 16'd5, 32'hA000_0002, 1'b0);
        checkOutput("jmp_wins_addr", imem_addr, 32'd8);
        doInstr("br_nt", 1'b0, 32'h0000_0100, 1'b1, 1'b0, 16'd100, 32'hA000_0003, 1'b0);
        checkOutput("br_nt_addr", imem_addr, 32'd9);
        doInstr("br_zext", 1'b0, 32'hDEAD_0000, 1'b1, 1'b1, 16'h8000, 32'hA000_0004, 1'b0);
        checkOutput("br_zext_addr", imem_addr, 32'h0000_8009);
        doInstr("jmp_top", 1'b1, 32'hFFFF_7FF6, 1'b0, 1'b0, 16'd0, 32'hA000_0005, 1'b0);
        checkOutput("jmp_top_addr", imem_addr, 32'hFFFF_FFFF);
        doInstr("br_wrap", 1'b0, 32'd0, 1'b1, 1'b1, 16'd2, 32'hA000_0006, 1'b0);
        checkOutput("br_wrap_addr", imem_addr, 32'd1);
        doInstr("jmp_back", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 16'd0, 32'hA000_0007, 1'b0);
        checkOutput("jmp_back_addr", imem_addr, 32'hFFFF_FFFF);
        doInstr("seq_wrap", 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 32'hA000_0008, 1'b0);
        checkOutput("seq_wrap_addr", imem_addr, 32'd0);
        doInstr("jmp7", 1'b1, 32'd7, 1'b0, 1'b0, 16'd0, 32'hA000_0009, 1'b0);
        checkOutput("jmp7_addr", imem_addr, 32'd7);

        // Grant delayed 4 cycles with a stray rvalid during REQ
        applyStimulus(1'b0, 1'b1, 32'hDEAD_DEAD, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("gntwait_req",  32'(imem_req), 32'd1);
            checkOutput("gntwait_addr", imem_addr,     32'd7);
            checkOutput("gntwait_inst", inst,          32'hA000_0009);
        end
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("resp_req",   32'(imem_req), 32'd0);
        checkOutput("resp_stray", inst,          32'hA000_0009);
        // Response delayed 2 cycles; grant left high and must be ignored
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("rvwait_valid", 32'(inst_valid), 32'd0);
            checkOutput("rvwait_req",   32'(imem_req),   32'd0);
        end
        applyStimulus(1'b0, 1'b1, 32'hBEEF_0007, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rv_inst",  inst,            32'hBEEF_0007);
        checkOutput("rv_valid", 32'(inst_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("exec_hold_inst",  inst,            32'hBEEF_0007);
        checkOutput("exec_hold_valid", 32'(inst_valid), 32'd1);

        // Retire with halt request at pc 7
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        @(negedge clk);
        expRetired = expRetired + 32'd1;
        checkOutput("halt_halted",  32'(halted), 32'd1);
        checkOutput("halt_pc",      pc,          32'd8);
        checkOutput("halt_retired", retired,     32'd14);
        // Everything except resume is ignored while halted
        applyStimulus(1'b1, 1'b1, 32'd0, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("halt_noreq",  32'(imem_req), 32'd0);
            checkOutput("halt_stay",   32'(halted),   32'd1);
        end
        checkOutput("halt_retired_hold", retired, 32'd14);
        checkOutput("halt_pc_hold",      pc,      32'd8);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        @(negedge clk);
        idleInputs();
        checkOutput("resume_req",    32'(imem_req), 32'd1);
        checkOutput("resume_addr",   imem_addr,     32'd8);
        checkOutput("resume_halted", 32'(halted),   32'd0);

        // Reset asserted while waiting in RESP
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("prerst_req", 32'(imem_req), 32'd0);
        idleInputs();
        rst = 1'b0;
        #1;
        checkOutput("midrst_pc",      pc,              32'd0);
        checkOutput("midrst_retired", retired,         32'd0);
        checkOutput("midrst_valid",   32'(inst_valid), 32'd0);
        checkOutput("midrst_inst",    inst,            32'd0);
        checkOutput("midrst_addr",    imem_addr,       32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        idleInputs();
        checkOutput("late_rv_inst", inst,          32'd0);
        checkOutput("restart_req",  32'(imem_req), 32'd1);
        checkOutput("restart_addr", imem_addr,     32'd0);
        expRetired = 32'd0;
        doInstr("post_rst", 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 32'hC0DE_0001, 1'b0);
        checkOutput("post_rst_addr", imem_addr, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_sequencer
